// File: rtl/ram_arbiter_if.sv
// Bus bundle between CPU controller, program loader, RAM and the RAM arbiter.
// slave = arbiter side, master = surrounding system (controller, loader, RAM).
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              cpu_addr_load;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rd_en;
  logic              cpu_halt;
  logic [DATA_W-1:0] cpu_rd_data;
  logic              cpu_stall;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_addr_load, cpu_addr, cpu_rd_en, cpu_halt,
    input  ld_req, ld_addr, ld_data, ram_rdata,
    output cpu_rd_data, cpu_stall, ld_ack, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output cpu_addr_load, cpu_addr, cpu_rd_en, cpu_halt,
    output ld_req, ld_addr, ld_data, ram_rdata,
    input  cpu_rd_data, cpu_stall, ld_ack, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/ram_arbiter.sv
// Arbitrates the shared program/data RAM between CPU MAR accesses and the program loader.
// Owns the MAR; stalls the controller while the loader holds the RAM.
module ram_arbiter #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input logic         clk,
  input logic         rst,
  ram_arbiter_if.slave bus
);
  localparam int unsigned BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, BUSY, LOAD, GAP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              load_own;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mar_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    burst_d = burst_q;
    unique case (state_q)
      // GAP differs from IDLE only in that it always leaves after one cycle
      IDLE, GAP: begin
        if (bus.cpu_addr_load) begin
          state_d = BUSY;
          mar_d   = bus.cpu_addr;
        end else if (bus.ld_req) begin
          state_d = LOAD;
          burst_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus.cpu_addr_load) begin
          mar_d = bus.cpu_addr;
        end else if (bus.cpu_rd_en) begin
          state_d = bus.ld_req ? LOAD : IDLE;
          burst_d = '0;
        end
      end
      LOAD: begin
        if (!bus.ld_req) begin
          state_d = IDLE;
        end else if (burst_q == LAST) begin
          burst_d = '0;
          state_d = bus.cpu_halt ? LOAD : GAP;
        end else begin
          burst_d = burst_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_own        = (state_q == LOAD);
  assign bus.cpu_stall   = load_own;
  assign bus.ld_ack      = load_own;
  assign bus.ram_we      = bus.ld_req && load_own;
  assign bus.ram_addr    = load_own ? bus.ld_addr : mar_q;
  assign bus.ram_wdata   = bus.ld_data;
  assign bus.cpu_rd_data = bus.ram_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic checked against a
// behavioural ownership/RAM model.
module tb_ram_arbiter;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  ram_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] ram [16];
  always @(posedge clk) if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
  assign bus.ram_rdata = ram[bus.ram_addr];

  // reference model: who owns the RAM, pending CPU read, writes done in this burst
  logic [7:0] mem [16];
  bit         m_load, m_busy;
  int         m_cnt;
  logic [3:0] m_mar;

  int errors = 0;
  int checks = 0;
  logic       obs_we, obs_stall;
  logic [7:0] obs_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic al, input logic [3:0] a, input logic rd,
                              input logic h, input logic lr, input logic [3:0] la,
                              input logic [7:0] ld);
    if (rst) begin
      m_load = 0; m_busy = 0; m_cnt = 0; m_mar = '0;
    end else if (m_load) begin
      if (lr) begin
        mem[la] = ld;
        m_cnt++;
        if (m_cnt == MAXB) begin
          m_cnt = 0;
          if (!h) m_load = 0;
        end
      end else begin
        m_load = 0;
      end
    end else if (m_busy) begin
      if (al) m_mar = a;
      else if (rd) begin
        m_busy = 0;
        if (lr) begin m_load = 1; m_cnt = 0; end
      end
    end else begin
      if (al) begin m_mar = a; m_busy = 1; end
      else if (lr) begin m_load = 1; m_cnt = 0; end
    end
  endtask

  // one clock cycle: drive at negedge, check mid-low-phase, advance model at posedge
  task automatic step(input logic al, input logic [3:0] a, input logic rd, input logic h,
                      input logic lr, input logic [3:0] la, input logic [7:0] ld);
    logic [3:0] ea;
    bus.cpu_addr_load = al; bus.cpu_addr = a; bus.cpu_rd_en = rd; bus.cpu_halt = h;
    bus.ld_req = lr; bus.ld_addr = la; bus.ld_data = ld;
    #1;
    ea = m_load ? la : m_mar;
    chk("stall", 32'(bus.cpu_stall), 32'(m_load));
    chk("ack",   32'(bus.ld_ack),    32'(m_load));
    chk("we",    32'(bus.ram_we),    32'(m_load && lr));
    chk("addr",  32'(bus.ram_addr),  32'(ea));
    chk("rdata", 32'(bus.cpu_rd_data), 32'(mem[ea]));
    obs_we = bus.ram_we; obs_stall = bus.cpu_stall; obs_rd = bus.cpu_rd_data;
    @(posedge clk);
    model_update(al, a, rd, h, lr, la, ld);
    @(negedge clk);
  endtask

  task automatic go_idle();
    step(0, 4'h0, 1, 0, 0, 4'h0, 8'h00);
    step(0, 4'h0, 0, 0, 0, 4'h0, 8'h00);
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_we"},    32'(bus.ram_we),    32'd0);
    chk({tag, "_ack"},   32'(bus.ld_ack),    32'd0);
    chk({tag, "_stall"}, 32'(bus.cpu_stall), 32'd0);
    chk({tag, "_addr"},  32'(bus.ram_addr),  32'd0);
    @(posedge clk);
    model_update(0, 4'h0, 0, 0, 0, 4'h0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic burst_run(input logic h, input logic [7:0] base,
                           output logic [15:0] pat, output int cyc);
    int idx = 0;
    pat = '0; cyc = 0;
    while (idx < 6 && cyc < 30) begin
      step(0, 4'h0, 0, h, 1, 4'(idx), base + 8'(idx));
      pat = {pat[14:0], obs_stall};
      cyc++;
      if (obs_we) idx++;
    end
    chk("burst_done", 32'(idx), 32'd6);
  endtask

  logic [15:0] pat;
  int          cyc;
  logic [7:0]  pre9;

  initial begin
    bus.cpu_addr_load = 0; bus.cpu_addr = '0; bus.cpu_rd_en = 0; bus.cpu_halt = 0;
    bus.ld_req = 0; bus.ld_addr = '0; bus.ld_data = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'($urandom);
      ram[i] = mem[i];
    end
    m_load = 0; m_busy = 0; m_cnt = 0; m_mar = '0;

    #1;
    chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_ack",   32'(bus.ld_ack),    32'd0);
    chk("rst_we",    32'(bus.ram_we),    32'd0);
    chk("rst_addr",  32'(bus.ram_addr),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // mid-run reset clears a loaded MAR
    step(1, 4'hB, 0, 0, 0, 4'h0, 8'h00);
    chk("mar_loaded", 32'(bus.ram_addr), 32'hB);
    reset_pulse("midrst");
    step(0, 4'h0, 0, 0, 0, 4'h0, 8'h00);

    // CPU read of a preset location
    ram[3] = 8'h2A; mem[3] = 8'h2A;
    step(1, 4'h3, 0, 0, 0, 4'h0, 8'h00);
    chk("rd_we0", 32'(obs_we), 32'd0);
    step(0, 4'h0, 1, 0, 0, 4'h0, 8'h00);
    chk("rd_data", 32'(obs_rd), 32'h2A);
    chk("rd_we1", 32'(obs_we), 32'd0);
    go_idle();

    // loader burst with forced CPU slot after MAX_BURST writes
    burst_run(0, 8'h10, pat, cyc);
    chk("gap_cycles", 32'(cyc), 32'd8);
    chk("gap_stall_pat", 32'(pat), 32'h007B);
    for (int i = 0; i < 6; i++) chk("gap_ram", 32'(ram[i]), 32'h10 + 32'(i));
    go_idle();

    // same burst with CPU halted: no gap
    burst_run(1, 8'h20, pat, cyc);
    chk("halt_cycles", 32'(cyc), 32'd7);
    chk("halt_stall_pat", 32'(pat), 32'h003F);
    for (int i = 0; i < 6; i++) chk("halt_ram", 32'(ram[i]), 32'h20 + 32'(i));
    go_idle();

    // CPU address load beats a simultaneous loader request
    ram[7] = 8'h5C; mem[7] = 8'h5C;
    step(1, 4'h7, 0, 0, 1, 4'h7, 8'h99);
    step(0, 4'h0, 0, 0, 1, 4'h7, 8'h99);
    chk("busy_noack", 32'(bus.ld_ack), 32'd0);
    step(0, 4'h0, 1, 0, 1, 4'h7, 8'h99);
    chk("busy_rd", 32'(obs_rd), 32'h5C);
    chk("busy_we", 32'(obs_we), 32'd0);
    step(0, 4'h0, 0, 0, 1, 4'h7, 8'h99);
    chk("busy_then_we", 32'(obs_we), 32'd1);
    chk("ram7_written", 32'(ram[7]), 32'h99);
    go_idle();

    // reset cuts a pending loader write; loader retries afterwards
    pre9 = ram[9];
    step(0, 4'h0, 0, 0, 1, 4'h9, 8'h55);
    bus.ld_req = 1; bus.ld_addr = 4'h9; bus.ld_data = 8'h55;
    #1;
    chk("cut_we_before", 32'(bus.ram_we), 32'd1);
    reset_pulse("cut");
    chk("cut_ram9", 32'(ram[9]), 32'(pre9));
    step(0, 4'h0, 0, 0, 1, 4'h9, 8'h55);
    step(0, 4'h0, 0, 0, 1, 4'h9, 8'h55);
    chk("retry_we", 32'(obs_we), 32'd1);
    go_idle();
    chk("retry_ram9", 32'(ram[9]), 32'h55);

    // random traffic against the model
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 3) == 0), 4'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 16; i++) chk("final_ram", 32'(ram[i]), 32'(mem[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
